// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: per-stage payload widths, control bundle
// and bubble constants used as reset/flush values of the stage registers.
package riscv_pipe_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [2:0] mem_op;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [3:0] alu_ctl;
        logic [2:0] branch;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // pc + instr; ctrl + pc + rs1 + rs2 + imm + three indices; ...
    localparam int IF_ID_W  = 2 * XLEN;
    localparam int ID_EX_W  = CTRL_W + 4 * XLEN + 3 * RIDX;
    localparam int EX_MEM_W = CTRL_W + 2 * XLEN + RIDX;
    localparam int MEM_WB_W = CTRL_W + 2 * XLEN + RIDX;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  =
        {CTRL_NOP, {(ID_EX_W - CTRL_W){1'b0}}};
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP =
        {CTRL_NOP, {(EX_MEM_W - CTRL_W){1'b0}}};
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP =
        {CTRL_NOP, {(MEM_WB_W - CTRL_W){1'b0}}};

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// slave = the stage register, master = the surrounding stages.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush and async reset.
// PIPE_SKID_EN adds a skid slot so in_ready comes straight from a flop.
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] DATA_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_reg_if.slave   bus
);

    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("pipe_stage_reg: WIDTH out of range");
    end

    logic             m_valid;
    logic             m_valid_d;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_data_d;
    logic             in_hs;
    logic             out_hs;
    logic             m_free;

    assign out_hs = m_valid && bus.out_ready;
    assign m_free = !m_valid || out_hs;
    assign in_hs  = bus.in_valid && bus.in_ready;

`ifdef PIPE_SKID_EN
    logic             s_valid;
    logic             s_valid_d;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] s_data_d;
    logic             rdy_q;

    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        s_valid_d = s_valid;
        s_data_d  = s_data;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = DATA_RST;
            s_valid_d = 1'b0;
        end else if (m_free) begin
            // rdy_q is low whenever S is full, so in_hs and s_valid exclude
            if (s_valid) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = in_hs;
                if (in_hs) m_data_d = bus.in_data;
            end
        end else if (in_hs) begin
            s_valid_d = 1'b1;
            s_data_d  = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_valid <= 1'b0;
            s_data  <= DATA_RST;
            rdy_q   <= 1'b0;
        end else begin
            s_valid <= s_valid_d;
            s_data  <= s_data_d;
            rdy_q   <= !s_valid_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.occupancy = {1'b0, m_valid} + {1'b0, s_valid};
`else
    logic rst_done;

    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = DATA_RST;
        end else if (m_free) begin
            m_valid_d = in_hs;
            if (in_hs) m_data_d = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    assign bus.in_ready  = rst_done && m_free;
    assign bus.occupancy = {1'b0, m_valid};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= DATA_RST;
        end else begin
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
        end
    end

    assign bus.out_valid = m_valid;
    assign bus.out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_pipe_stage_reg;

    localparam int W = 32;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    pipe_stage_reg_if #(.WIDTH(W)) bus ();

    pipe_stage_reg #(
        .WIDTH(W),
        .DATA_RST('0)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int max_occ = 0;

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: ordered list of payloads held by the stage
    logic [W-1:0] q[$];
    bit started = 1'b0;
    bit clean = 1'b1;
    bit m_ih;
    bit m_oh;

    function automatic bit exp_rdy();
        if (!started) return 1'b0;
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || bus.out_ready;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            started = 1'b0;
            clean = 1'b1;
        end else begin
            m_ih = bus.in_valid && exp_rdy();
            m_oh = q.size() > 0 && bus.out_ready;
            started = 1'b1;
            if (m_oh) void'(q.pop_front());
            if (flush) begin
                q.delete();
                clean = 1'b1;
            end else if (m_ih) begin
                q.push_back(bus.in_data);
                clean = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", W'(bus.out_valid), W'(q.size() > 0));
        chk("occupancy", W'(bus.occupancy), W'(q.size()));
        chk("in_ready", W'(bus.in_ready), W'(exp_rdy()));
        if (q.size() > 0)
            chk("out_data", bus.out_data, q[0]);
        else if (clean)
            chk("out_data_rst", bus.out_data, '0);
        if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
    end

    task automatic step(bit v, logic [W-1:0] d, bit ordy, bit fl);
        #1;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = ordy;
        flush = fl;
        @(negedge clk);
    endtask

    task automatic lit(string n, bit v, logic [W-1:0] d, int occ);
        chk({n, "_valid"}, W'(bus.out_valid), W'(v));
        chk({n, "_occ"}, W'(bus.occupancy), W'(occ));
        if (v) chk({n, "_data"}, bus.out_data, d);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEAD_BEEF;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst", 1'b0, '0, 0);
        chk("rst_data", bus.out_data, '0);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", W'(bus.in_ready), 1);
        chk("rst_after_valid", W'(bus.out_valid), 0);

        for (int i = 1; i <= 10; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            lit("stream", 1'b1, W'(i), 1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        lit("stream_end", 1'b0, '0, 0);

`ifdef PIPE_SKID_EN
        step(1'b1, 32'hA, 1'b0, 1'b0);
        lit("stall_a", 1'b1, 32'hA, 1);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        lit("stall_b", 1'b1, 32'hA, 2);
        chk("stall_rdy", W'(bus.in_ready), 0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        lit("stall_c", 1'b1, 32'hA, 2);
        chk("stall_rdy_c", W'(bus.in_ready), 0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        lit("drain_b", 1'b1, 32'hB, 1);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        lit("drain_c", 1'b1, 32'hC, 1);
        step(1'b0, '0, 1'b1, 1'b0);
        lit("drain_end", 1'b0, '0, 0);
`else
        step(1'b1, 32'hA, 1'b0, 1'b0);
        lit("ns_stall", 1'b1, 32'hA, 1);
        chk("ns_rdy_low", W'(bus.in_ready), 0);
        #1 bus.out_ready = 1'b1;
        #1 chk("ns_rdy_comb", W'(bus.in_ready), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        lit("ns_drain", 1'b0, '0, 0);
`endif

        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        lit("full", 1'b1, 32'hA, CAP);
        step(1'b1, 32'h55, 1'b0, 1'b1);
        lit("flush_full", 1'b0, '0, 0);
        chk("flush_full_data", bus.out_data, '0);
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b0, 1'b1);
        lit("flush_hs", 1'b0, '0, 0);
        chk("flush_hs_data", bus.out_data, '0);
        step(1'b0, '0, 1'b1, 1'b0);
        lit("flush_gone", 1'b0, '0, 0);

        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        lit("pre_areset", 1'b1, 32'h11, CAP);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", W'(bus.out_valid), 0);
        chk("areset_occ", W'(bus.occupancy), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("areset_rdy", W'(bus.in_ready), 1);

        repeat (500) begin
            step($urandom_range(0, 3) != 0, W'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        chk("max_occ", W'(max_occ), W'(CAP));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
